// File: rtl/probe_sequencer_if.sv
// Register bus, run control and synthesiser handshake
// shared by probe_sequencer and its environment.
interface probe_sequencer_if;
  logic        WR_EN;
  logic [15:0] ADDR;
  logic [31:0] DATA;
  logic        START;
  logic        ABORT;
  logic        BUSY;
  logic        DONE;
  logic        INITIED;
  logic        UPDATE;
  logic        UPDATED;

  modport master (
    output WR_EN, ADDR, DATA, START, ABORT,
    output INITIED, UPDATED,
    input  BUSY, DONE, UPDATE
  );

  modport slave (
    input  WR_EN, ADDR, DATA, START, ABORT,
    input  INITIED, UPDATED,
    output BUSY, DONE, UPDATE
  );
endinterface

// File: rtl/probe_sequencer.sv
// Probe run sequencer: groups > steps > reps > codes.
// Define HOP_TABLE_EN for the freq_mode 2 hop table.
module probe_sequencer #(
  parameter int CODE_W     = 32,
  parameter int CODE_DEPTH = 32,
  parameter int FREQW_W    = 32,
  parameter int CNT_W      = 16,
  parameter int BASE_ADDR  = 120
) (
  input  logic               CLOCK_10M,
  input  logic               RESET,
  probe_sequencer_if.slave   bus,
  output logic [FREQW_W-1:0] FREQW,
  output logic               PRE_GEN,
  output logic               GEN,
  output logic [CODE_W-1:0]  CODE,
  output logic [CNT_W-1:0]   CODE_LEN,
  output logic [CNT_W-1:0]   CODE_DURATION,
  output logic [CNT_W-1:0]   PULSE_LEN,
  output logic [7:0]         PROBE_MODE,
  output logic               RF_OUTPUT_EN,
  input  logic               SIGNAL_GEN_OVER,
  input  logic               RECEIVER_OVER
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_GROUP, S_STEP, S_UPD, S_UPDW,
    S_REP, S_CODE, S_PRE, S_GEN, S_INTV, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [7:0]         r_probe_mode, r_freq_mode;
  logic [CNT_W-1:0]   r_interval, r_groups, r_reps;
  logic [CNT_W-1:0]   r_steps, r_code_count, r_code_len;
  logic [CNT_W-1:0]   r_code_dur, r_pulse_len, r_pre_delay;
  logic [FREQW_W-1:0] r_start, r_step;
  logic [CODE_W-1:0]  r_code_tab [CODE_DEPTH];

  logic               r_start_q;
  logic [CNT_W-1:0]   r_grp, r_stp, r_rep, r_cod, r_cnt;

  logic [15:0]        w_off;
  logic               w_we, w_busy, w_start_edge;
  logic               w_intv, w_both, w_hop_mode;
  logic [CNT_W-1:0]   w_ncode;
  logic [CODE_W-1:0]  w_code_sel;
  logic [FREQW_W-1:0] w_hop_sel;
  logic               w_done, w_upd;

  assign w_off = bus.ADDR - 16'(BASE_ADDR);
  assign w_we = bus.WR_EN && !w_busy;
  assign w_start_edge = bus.START && !r_start_q;
  assign w_both = SIGNAL_GEN_OVER && RECEIVER_OVER;
  assign w_ncode =
    (r_code_count > CNT_W'(CODE_DEPTH)) ?
    CNT_W'(CODE_DEPTH) : r_code_count;
  assign w_intv =
    ((r_grp + ONE) < r_groups) && (r_interval != '0);

  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      r_probe_mode <= '0;
      r_interval   <= '0;
      r_groups     <= '0;
      r_reps       <= '0;
      r_freq_mode  <= '0;
      r_start      <= '0;
      r_step       <= '0;
      r_steps      <= '0;
      r_code_count <= '0;
      r_code_len   <= '0;
      r_code_dur   <= '0;
      r_pulse_len  <= '0;
      r_pre_delay  <= CNT_W'(256);
      for (int i = 0; i < CODE_DEPTH; i++)
        r_code_tab[i] <= '0;
    end else if (w_we) begin
      case (w_off)
        16'd0:  r_probe_mode <= bus.DATA[7:0];
        16'd1:  r_interval   <= CNT_W'(bus.DATA);
        16'd2:  r_groups     <= CNT_W'(bus.DATA);
        16'd3:  r_reps       <= CNT_W'(bus.DATA);
        16'd4:  r_freq_mode  <= bus.DATA[7:0];
        16'd5:  r_start      <= FREQW_W'(bus.DATA);
        16'd6:  r_step       <= FREQW_W'(bus.DATA);
        16'd7:  r_steps      <= CNT_W'(bus.DATA);
        16'd8:  r_code_count <= CNT_W'(bus.DATA);
        16'd9:  r_code_len   <= CNT_W'(bus.DATA);
        16'd10: r_code_dur   <= CNT_W'(bus.DATA);
        16'd11: r_pulse_len  <= CNT_W'(bus.DATA);
        16'd12: r_pre_delay  <= CNT_W'(bus.DATA);
        default: ;
      endcase
      for (int i = 0; i < CODE_DEPTH; i++)
        if (w_off == 16'(16 + i))
          r_code_tab[i] <= CODE_W'(bus.DATA);
    end
  end

  always_comb begin
    w_code_sel = '0;
    for (int i = 0; i < CODE_DEPTH; i++)
      if (r_cod == CNT_W'(i))
        w_code_sel = r_code_tab[i];
  end

`ifdef HOP_TABLE_EN
  logic [FREQW_W-1:0] r_hop_tab [CODE_DEPTH];
  logic [CNT_W-1:0]   w_hidx;

  assign w_hidx = r_stp % CNT_W'(CODE_DEPTH);
  assign w_hop_mode = (r_freq_mode == 8'd2);

  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      for (int i = 0; i < CODE_DEPTH; i++)
        r_hop_tab[i] <= '0;
    end else if (w_we) begin
      for (int i = 0; i < CODE_DEPTH; i++)
        if (w_off == 16'(64 + i))
          r_hop_tab[i] <= FREQW_W'(bus.DATA);
    end
  end

  always_comb begin
    w_hop_sel = '0;
    for (int i = 0; i < CODE_DEPTH; i++)
      if (w_hidx == CNT_W'(i))
        w_hop_sel = r_hop_tab[i];
  end
`else
  assign w_hop_mode = 1'b0;
  assign w_hop_sel  = '0;
`endif

  always_ff @(posedge CLOCK_10M) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_edge) w_next = S_ARM;
      S_ARM:   if (bus.INITIED)
                 w_next = (r_groups == '0) ? S_DONE : S_GROUP;
      S_GROUP: w_next = (r_grp < r_groups) ? S_STEP : S_DONE;
      S_STEP:  if (r_stp < r_steps) w_next = S_UPD;
               else if (w_intv)     w_next = S_INTV;
               else                 w_next = S_GROUP;
      S_UPD:   if (bus.UPDATED)  w_next = S_UPDW;
      S_UPDW:  if (!bus.UPDATED) w_next = S_REP;
      S_REP:   w_next = (r_rep < r_reps) ? S_CODE : S_STEP;
      S_CODE:  w_next = (r_cod < w_ncode) ? S_PRE : S_REP;
      S_PRE:   if (r_cnt == r_pre_delay) w_next = S_GEN;
      S_GEN:   if (w_both) w_next = S_CODE;
      S_INTV:  if (r_cnt == r_interval - ONE) w_next = S_GROUP;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.ABORT && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_comb begin
    w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    w_done  = (r_state == S_DONE);
    w_upd   = (r_state == S_UPD);
    GEN     = (r_state == S_GEN);
    PRE_GEN = (r_state == S_PRE) || (r_state == S_GEN);
    RF_OUTPUT_EN = (r_state != S_IDLE) &&
      (PROBE_MODE == 8'd1 || PROBE_MODE == 8'd2 ||
       PROBE_MODE == 8'd5);
  end

  assign bus.BUSY   = w_busy;
  assign bus.DONE   = w_done;
  assign bus.UPDATE = w_upd;

  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      r_start_q     <= 1'b0;
      r_grp         <= '0;
      r_stp         <= '0;
      r_rep         <= '0;
      r_cod         <= '0;
      r_cnt         <= '0;
      FREQW         <= '0;
      CODE          <= '0;
      CODE_LEN      <= '0;
      CODE_DURATION <= '0;
      PULSE_LEN     <= '0;
      PROBE_MODE    <= '0;
    end else begin
      r_start_q <= bus.START;
      unique case (r_state)
        S_IDLE: if (w_start_edge) begin
          CODE_LEN      <= r_code_len;
          CODE_DURATION <= r_code_dur;
          PULSE_LEN     <= r_pulse_len;
          PROBE_MODE    <= r_probe_mode;
        end
        S_ARM: r_grp <= '0;
        S_GROUP: begin
          FREQW <= r_start;
          r_stp <= '0;
        end
        S_STEP: if (r_stp < r_steps) begin
          r_rep <= '0;
          if (w_hop_mode) FREQW <= w_hop_sel;
        end else begin
          r_grp <= r_grp + ONE;
          r_cnt <= '0;
        end
        S_REP: if (r_rep < r_reps) begin
          r_cod <= '0;
        end else begin
          r_stp <= r_stp + ONE;
          // mode 1 holds; hop mode reloads in STEP
          if (r_freq_mode != 8'd1 && !w_hop_mode)
            FREQW <= FREQW + r_step;
        end
        S_CODE: if (r_cod < w_ncode) begin
          CODE  <= w_code_sel;
          r_cnt <= '0;
        end else begin
          r_rep <= r_rep + ONE;
        end
        S_PRE, S_INTV: r_cnt <= r_cnt + ONE;
        S_GEN: if (w_both) r_cod <= r_cod + ONE;
        default: ;
      endcase
    end
  end
endmodule
